// File: rtl/spi_pkg.sv
// Shared widths, FSM encoding and constants for the SPI arbiter slice.
package spi_pkg;

    localparam int SPI_DATA_W  = 32;
    localparam int SPI_NBITS_W = 5;

    localparam logic [SPI_DATA_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } spi_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request strictly after ptr,
// wrapping around, wins.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   win,
    output logic               any
);

    logic [PTR_W-1:0]     start;
    logic [2*NUM_REQ-1:0] rot;

    assign start = (ptr == PTR_W'(NUM_REQ - 1)) ? '0 : ptr + PTR_W'(1);
    assign rot   = {req, req} >> start;

    // rot[k] is the request k positions after start; the lowest such k wins.
    always_comb begin
        int w;
        win = '0;
        any = 1'b0;
        w   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && rot[k]) begin
                w = int'(start) + k;
                if (w >= NUM_REQ) begin
                    w = w - NUM_REQ;
                end
                win = PTR_W'(w);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ clients, with a
// per-phase watchdog that aborts a stuck handshake.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*SPI_DATA_W-1:0] req_mosi_data,
    input  logic [NUM_REQ*SPI_NBITS_W-1:0] req_nbits,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [SPI_DATA_W-1:0]         rsp_miso_data,
    output logic                          rsp_timeout,
    output logic [SPI_DATA_W-1:0]         spi_mosi_data,
    output logic [SPI_NBITS_W-1:0]        spi_nbits,
    output logic                          spi_request,
    input  logic                          spi_ready,
    input  logic [SPI_DATA_W-1:0]         spi_miso_data,
    output logic                          busy,
    output logic [7:0]                    err_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    spi_state_t             state;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       owner;
    logic [CNT_W-1:0]       cnt;
    logic [PTR_W-1:0]       win;
    logic                   any;
    logic                   phase_exit;
    logic [SPI_DATA_W-1:0]  data_arr  [NUM_REQ];
    logic [SPI_NBITS_W-1:0] nbits_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i]  = req_mosi_data[SPI_DATA_W*i +: SPI_DATA_W];
        assign nbits_arr[i] = req_nbits[SPI_NBITS_W*i +: SPI_NBITS_W];
    end

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req(req_valid),
        .ptr(ptr),
        .win(win),
        .any(any)
    );

    // WAIT_BUSY leaves when the master goes busy, WAIT_DONE when it is ready again.
    assign phase_exit = (state == ST_WAIT_BUSY) ? !spi_ready : spi_ready;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            ptr           <= PTR_W'(NUM_REQ - 1);
            owner         <= '0;
            cnt           <= '0;
            req_grant     <= '0;
            rsp_valid     <= '0;
            rsp_miso_data <= '0;
            rsp_timeout   <= 1'b0;
            spi_mosi_data <= '0;
            spi_nbits     <= '0;
            spi_request   <= 1'b0;
            busy          <= 1'b0;
            err_count     <= '0;
        end else begin
            req_grant   <= '0;
            rsp_valid   <= '0;
            rsp_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (spi_ready && any) begin
                        spi_mosi_data  <= data_arr[win];
                        spi_nbits      <= nbits_arr[win];
                        req_grant[win] <= 1'b1;
                        spi_request    <= 1'b1;
                        owner          <= win;
                        ptr            <= win;
                        cnt            <= '0;
                        busy           <= 1'b1;
                        state          <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    if (phase_exit && state == ST_WAIT_BUSY) begin
                        spi_request <= 1'b0;
                        cnt         <= '0;
                        state       <= ST_WAIT_DONE;
                    end else if (phase_exit) begin
                        rsp_miso_data    <= spi_miso_data;
                        rsp_valid[owner] <= 1'b1;
                        busy             <= 1'b0;
                        state            <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        // Abort: hand the owner a poisoned word flagged as timed out.
                        spi_request      <= 1'b0;
                        rsp_miso_data    <= TIMEOUT_DATA;
                        rsp_valid[owner] <= 1'b1;
                        rsp_timeout      <= 1'b1;
                        busy             <= 1'b0;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter with two clients and a short
// timeout so saturation of err_count stays within a small cycle budget.
module tb_spi_arbiter;

    localparam int NUM_REQ = 2;
    localparam int T       = 32;

    logic                clk_in = 1'b0;
    logic                rst;
    logic [1:0]          req_valid;
    logic [63:0]         req_mosi_data;
    logic [9:0]          req_nbits;
    logic [1:0]          req_grant;
    logic [1:0]          rsp_valid;
    logic [31:0]         rsp_miso_data;
    logic                rsp_timeout;
    logic [31:0]         spi_mosi_data;
    logic [4:0]          spi_nbits;
    logic                spi_request;
    logic                spi_ready;
    logic [31:0]         spi_miso_data;
    logic                busy;
    logic [7:0]          err_count;

    int total = 0;
    int bad   = 0;

    spi_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_mosi_data(req_mosi_data),
        .req_nbits    (req_nbits),
        .req_grant    (req_grant),
        .rsp_valid    (rsp_valid),
        .rsp_miso_data(rsp_miso_data),
        .rsp_timeout  (rsp_timeout),
        .spi_mosi_data(spi_mosi_data),
        .spi_nbits    (spi_nbits),
        .spi_request  (spi_request),
        .spi_ready    (spi_ready),
        .spi_miso_data(spi_miso_data),
        .busy         (busy),
        .err_count    (err_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a grant, then plays a well-behaved master.
    task automatic applyStimulus(input logic [31:0] miso, input int busy_len,
                                 output logic [1:0] grant, output logic [31:0] mosi,
                                 output logic [1:0] rsp, output logic [31:0] data,
                                 output logic tmo);
        grant = '0;
        mosi  = '0;
        rsp   = '0;
        data  = '0;
        tmo   = 1'b0;
        for (int i = 0; i < 4 && grant == 2'b00; i++) begin
            tick();
            grant = req_grant;
            mosi  = spi_mosi_data;
        end
        if (grant != 2'b00) begin
            tick();
            spi_ready = 1'b0;
            tick();
            for (int i = 0; i < busy_len; i++) tick();
            spi_miso_data = miso;
            spi_ready     = 1'b1;
            tick();
            rsp  = rsp_valid;
            data = rsp_miso_data;
            tmo  = rsp_timeout;
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  g, r, acc;
        logic [31:0] m, d;
        logic        t;
        int          c;

        rst = 1'b1;
        req_valid = '0;
        req_mosi_data = '0;
        req_nbits = '0;
        spi_ready = 1'b1;
        spi_miso_data = '0;
        doReset();
        checkOutput("reset_data", 64'({rsp_miso_data, spi_mosi_data}), 64'd0);
        checkOutput("reset_ctrl", 64'({req_grant, rsp_valid, rsp_timeout, spi_nbits, spi_request, busy, err_count}), 64'd0);

        // Single client 0: 0x8F00, 16 bits, MISO 0x0033.
        req_mosi_data = {32'h0000_0000, 32'h0000_8F00};
        req_nbits     = {5'd0, 5'd15};
        req_valid     = 2'b01;
        tick();
        checkOutput("single_grant", 64'(req_grant), 64'(2'b01));
        checkOutput("single_req", 64'({spi_request, busy}), 64'(2'b11));
        checkOutput("single_mosi", 64'({spi_mosi_data, spi_nbits}), 64'({32'h0000_8F00, 5'd15}));
        req_valid = 2'b00;
        tick();
        checkOutput("single_hold", 64'({req_grant, spi_request}), 64'(3'b001));
        spi_ready = 1'b0;
        tick();
        checkOutput("single_req_drop", 64'(spi_request), 64'd0);
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            acc |= rsp_valid;
        end
        checkOutput("single_no_early_rsp", 64'(acc), 64'd0);
        spi_miso_data = 32'h0000_0033;
        spi_ready = 1'b1;
        tick();
        checkOutput("single_rsp", 64'({rsp_valid, rsp_timeout, busy}), 64'(4'b0100));
        checkOutput("single_miso", 64'(rsp_miso_data), 64'h33);
        tick();
        checkOutput("single_mosi_hold", 64'({rsp_valid, spi_mosi_data}), 64'({2'b00, 32'h0000_8F00}));

        // Contention: both clients held, fresh pointer.
        doReset();
        req_mosi_data = {32'h2222_0001, 32'h1111_0000};
        req_nbits     = {5'd7, 5'd31};
        req_valid     = 2'b11;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(32'hA000 + 32'(n), 3, g, m, r, d, t);
            c = n % 2;
            checkOutput("cont_grant", 64'(g), (c == 0) ? 64'(2'b01) : 64'(2'b10));
            checkOutput("cont_mosi", 64'(m), (c == 0) ? 64'h1111_0000 : 64'h2222_0001);
            checkOutput("cont_rsp", 64'({r, t}), (c == 0) ? 64'(3'b010) : 64'(3'b100));
            checkOutput("cont_miso", 64'(d), 64'(32'hA000 + 32'(n)));
        end
        req_valid = 2'b00;

        // Withdrawal: client 1 appears then leaves while client 0 is served.
        doReset();
        req_valid = 2'b01;
        tick();
        checkOutput("wd_grant0", 64'(req_grant), 64'(2'b01));
        req_valid = 2'b10;
        tick();
        spi_ready = 1'b0;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        spi_miso_data = 32'h0000_005A;
        spi_ready = 1'b1;
        tick();
        checkOutput("wd_rsp0", 64'({rsp_valid, rsp_miso_data}), 64'({2'b01, 32'h0000_005A}));
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            acc |= req_grant;
        end
        checkOutput("wd_no_grant", 64'({acc, busy}), 64'd0);
        req_valid = 2'b11;
        applyStimulus(32'h0000_0077, 2, g, m, r, d, t);
        req_valid = 2'b00;
        checkOutput("wd_ptr_kept", 64'(g), 64'(2'b10));

        // Stuck master: ready never drops after the grant.
        req_valid = 2'b01;
        tick();
        checkOutput("stuck_grant", 64'(req_grant), 64'(2'b01));
        req_valid = 2'b00;
        acc = '0;
        for (int i = 1; i < T; i++) begin
            tick();
            acc |= rsp_valid;
        end
        checkOutput("stuck_pre", 64'({acc, spi_request}), 64'(3'b001));
        tick();
        checkOutput("stuck_rsp", 64'({rsp_valid, rsp_timeout, spi_request, busy}), 64'(5'b01100));
        checkOutput("stuck_data", 64'({rsp_miso_data, err_count}), 64'({32'hFFFF_FFFF, 8'd1}));

        // Hung transfer: ready never returns.
        req_valid = 2'b10;
        tick();
        checkOutput("hung_grant", 64'(req_grant), 64'(2'b10));
        req_valid = 2'b00;
        tick();
        spi_ready = 1'b0;
        tick();
        acc = '0;
        for (int i = 1; i < T; i++) begin
            tick();
            acc |= rsp_valid;
        end
        checkOutput("hung_pre", 64'(acc), 64'd0);
        tick();
        checkOutput("hung_rsp", 64'({rsp_valid, rsp_timeout, err_count}), 64'({2'b10, 1'b1, 8'd2}));
        spi_ready = 1'b1;

        // Force timeouts up to 300 in total; the counter must stop at 255.
        for (int n = 3; n <= 300; n++) begin
            req_valid = 2'b01;
            tick();
            req_valid = 2'b00;
            for (int i = 0; i < T; i++) tick();
            if (n == 254) checkOutput("sat_254", 64'(err_count), 64'd254);
        end
        checkOutput("sat_255", 64'({err_count, rsp_timeout}), 64'({8'd255, 1'b1}));

        // Reset while client 0 sits in WAIT_DONE, client 1 pending.
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        spi_ready = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_data", 64'({rsp_miso_data, spi_mosi_data}), 64'd0);
        checkOutput("rst_mid_ctrl", 64'({req_grant, rsp_valid, rsp_timeout, spi_nbits, spi_request, busy, err_count}), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            acc |= req_grant | rsp_valid;
        end
        checkOutput("rst_busy_master", 64'({acc, busy}), 64'd0);
        spi_ready = 1'b1;
        tick();
        checkOutput("rst_grant1", 64'({req_grant, spi_request, spi_mosi_data}), 64'({2'b10, 1'b1, 32'h2222_0001}));
        req_valid = 2'b00;
        tick();
        spi_ready = 1'b0;
        tick();
        spi_miso_data = 32'h0000_0BEE;
        spi_ready = 1'b1;
        tick();
        checkOutput("rst_rsp1", 64'({rsp_valid, rsp_miso_data}), 64'({2'b10, 32'h0000_0BEE}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
